ads8689_ram_reader: RTL and testbench

Read-side consumer of the ADS8689 sample DPBRAM. The ADC controller writes one 32-bit SPI word per 10 µs conversion into port A as a ping-pong buffer and reports which half it is writing. This block watches that half indication. Each time the writer leaves a half, it reads the completed half through port B, streams the samples out over a valid/ready interface, and publishes the block average.

---
 rtl/ads8689_ram_reader_if.sv | 24 ++
 rtl/ads8689_ram_reader.sv | 145 ++++++++++++++
 tb/tb_ads8689_ram_reader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads8689_ram_reader_if.sv
// ADS8689 reader bus: DPBRAM port B read channel plus the outgoing sample stream.
// master = reader block; slave = RAM port B and the downstream sample consumer.
// i_ram_dout arrives RAM_LATENCY cycles after o_ram_en; i_smp_ready throttles the stream.
`timescale 1ns/1ps
interface ads8689_ram_reader_if;
  logic [10:0] o_ram_addr;
  logic        o_ram_en;
  logic [31:0] i_ram_dout;
  logic [15:0] o_smp_data;
  logic        o_smp_valid;
  logic        i_smp_ready;
  logic        o_smp_last;
  logic        o_smp_half;

  modport master (
    output o_ram_addr, o_ram_en, o_smp_data, o_smp_valid, o_smp_last, o_smp_half,
    input  i_ram_dout, i_smp_ready
  );

  modport slave (
    input  o_ram_addr, o_ram_en, o_smp_data, o_smp_valid, o_smp_last, o_smp_half,
    output i_ram_dout, i_smp_ready
  );
endinterface

// File: rtl/ads8689_ram_reader.sv
// Reads each completed ping-pong half of the ADS8689 sample RAM, streams it, publishes the mean.
// Latency: first sample valid 2+RAM_LATENCY cycles after the half flag toggles; avg 1 cycle after last accept.
// Backpressure: i_smp_ready low freezes the stream in OUT; no further RAM reads until the sample is taken.
`timescale 1ns/1ps
module ads8689_ram_reader #(
  parameter int RAM_DEPTH   = 2048,
  parameter int RAM_LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_ram_2_flag,
  ads8689_ram_reader_if.master bus,
  output logic [15:0]          o_avg_data,
  output logic                 o_avg_valid,
  output logic                 o_overrun,
  input  logic                 i_overrun_clr,
  output logic [2:0]           o_debug_state
);

  localparam int HALF  = RAM_DEPTH / 2;
  localparam int HW    = $clog2(HALF);
  localparam int SUM_W = 16 + HW;
  localparam int LW    = $clog2(RAM_LATENCY + 1);

  localparam logic [HW-1:0] IDX_LAST  = HW'(HALF - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(RAM_LATENCY - 1);
  localparam logic [10:0]   HALF_ADDR = 11'(HALF);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_AVG  = 3'd4,
    S_INIT = 3'd7
  } state_t;

  state_t                  state;
  logic                    flag_d;
  logic [HW-1:0]           idx;
  logic [LW-1:0]           lat_cnt;
  logic signed [SUM_W-1:0] sum;

  logic                    flag_edge;
  logic                    flag_rise;
  logic signed [SUM_W-1:0] smp_ext;
  logic                    unused_dout_lo;

  // Writer switching halves: rising = lower half finished, falling = upper half finished.
  assign flag_edge = i_wr_ram_2_flag ^ flag_d;
  assign flag_rise = i_wr_ram_2_flag & ~flag_d;

  // Sample sits in the upper 16 bits of the SPI word; the low bits carry no data.
  assign smp_ext        = {{HW{bus.i_ram_dout[31]}}, bus.i_ram_dout[31:16]};
  assign unused_dout_lo = ^bus.i_ram_dout[15:0];

  assign o_debug_state = state;

  // Reader FSM: edge detect, one RAM read per sample, stream handshake, block average, overrun flag.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state           <= S_INIT;
      flag_d          <= 1'b0;
      idx             <= '0;
      lat_cnt         <= '0;
      sum             <= '0;
      bus.o_ram_addr  <= '0;
      bus.o_ram_en    <= 1'b0;
      bus.o_smp_data  <= '0;
      bus.o_smp_valid <= 1'b0;
      bus.o_smp_last  <= 1'b0;
      bus.o_smp_half  <= 1'b0;
      o_avg_data      <= '0;
      o_avg_valid     <= 1'b0;
      o_overrun       <= 1'b0;
    end else if (state == S_INIT) begin
      // Adopt whatever half the writer is in now so reset release is not seen as an edge.
      flag_d <= i_wr_ram_2_flag;
      state  <= S_IDLE;
    end else begin
      flag_d      <= i_wr_ram_2_flag;
      o_avg_valid <= 1'b0;

      // A half completing while busy is dropped; a simultaneous clear loses to the new event.
      if (flag_edge && state != S_IDLE) begin
        o_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        o_overrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (flag_edge) begin
            bus.o_ram_addr <= flag_rise ? 11'd0 : HALF_ADDR;
            bus.o_smp_half <= ~flag_rise;
            sum            <= '0;
            idx            <= '0;
            bus.o_ram_en   <= 1'b1;
            state          <= S_READ;
          end
        end
        S_READ: begin
          bus.o_ram_en <= 1'b0;
          lat_cnt      <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            bus.o_smp_data  <= bus.i_ram_dout[31:16];
            sum             <= sum + smp_ext;
            bus.o_smp_valid <= 1'b1;
            bus.o_smp_last  <= (idx == IDX_LAST);
            state           <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.i_smp_ready) begin
            bus.o_smp_valid <= 1'b0;
            bus.o_smp_last  <= 1'b0;
            if (idx == IDX_LAST) begin
              // Dropping the low HW bits of the two's-complement sum is a floor divide by HALF.
              o_avg_data  <= sum[HW +: 16];
              o_avg_valid <= 1'b1;
              state       <= S_AVG;
            end else begin
              bus.o_ram_addr <= bus.o_ram_addr + 11'd1;
              idx            <= idx + 1'b1;
              bus.o_ram_en   <= 1'b1;
              state          <= S_READ;
            end
          end
        end
        S_AVG: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ads8689_ram_reader.sv
`timescale 1ns/1ps
module tb_ads8689_ram_reader;
  localparam int RAM_DEPTH   = 2048;
  localparam int RAM_LATENCY = 2;
  localparam int HALF        = RAM_DEPTH / 2;
  localparam int BUDGET      = HALF * 12;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_wr_ram_2_flag;
  logic        i_overrun_clr;
  logic [15:0] o_avg_data;
  logic        o_avg_valid;
  logic        o_overrun;
  logic [2:0]  o_debug_state;

  ads8689_ram_reader_if bus();

  ads8689_ram_reader #(.RAM_DEPTH(RAM_DEPTH), .RAM_LATENCY(RAM_LATENCY)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_wr_ram_2_flag (i_wr_ram_2_flag),
    .bus             (bus),
    .o_avg_data      (o_avg_data),
    .o_avg_valid     (o_avg_valid),
    .o_overrun       (o_overrun),
    .i_overrun_clr   (i_overrun_clr),
    .o_debug_state   (o_debug_state)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous RAM model: data for an enabled address appears RAM_LATENCY cycles later.
  logic [31:0] mem  [RAM_DEPTH];
  logic [31:0] pipe [RAM_LATENCY];
  always @(posedge i_clk) begin
    pipe[0] <= bus.o_ram_en ? mem[bus.o_ram_addr] : 32'hDEAD_BEEF;
    for (int k = 1; k < RAM_LATENCY; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.i_ram_dout = pipe[RAM_LATENCY-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // Random downstream ready, percentage set by the test.
  int ready_pct = 100;
  initial begin
    bus.i_smp_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      bus.i_smp_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor: record reads, handshakes and average pulses; flag stall-stability violations.
  logic [10:0] rd_addr [$];
  logic [15:0] hs_data [$];
  logic        hs_last [$];
  logic        hs_half [$];
  int          cyc = 0, avg_cnt = 0, avg_cyc = 0, last_hs_cyc = 0;
  int          stall_errs = 0, en_in_out_errs = 0;
  logic [15:0] avg_seen = '0;
  logic        prev_stall = 1'b0, prev_last = 1'b0, prev_half = 1'b0;
  logic [15:0] prev_data = '0;
  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      if (bus.o_ram_en) rd_addr.push_back(bus.o_ram_addr);
      if (bus.o_ram_en && bus.o_smp_valid) en_in_out_errs++;
      if (i_rst && prev_stall && (!bus.o_smp_valid || bus.o_smp_data != prev_data ||
                                  bus.o_smp_last != prev_last || bus.o_smp_half != prev_half))
        stall_errs++;
      if (bus.o_smp_valid && bus.i_smp_ready) begin
        hs_data.push_back(bus.o_smp_data);
        hs_last.push_back(bus.o_smp_last);
        hs_half.push_back(bus.o_smp_half);
        last_hs_cyc = cyc;
      end
      if (o_avg_valid) begin
        avg_cnt++;
        avg_cyc  = cyc;
        avg_seen = o_avg_data;
      end
      prev_stall = bus.o_smp_valid && !bus.i_smp_ready;
      prev_data  = bus.o_smp_data;
      prev_last  = bus.o_smp_last;
      prev_half  = bus.o_smp_half;
    end
  end

  task automatic clear_mon();
    rd_addr.delete(); hs_data.delete(); hs_last.delete(); hs_half.delete();
    avg_cnt = 0; stall_errs = 0; en_in_out_errs = 0;
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  // Reference: expected addresses, samples and floor mean of a completed half.
  logic [10:0] exp_addr [HALF];
  logic [15:0] exp_smp  [HALF];
  logic [15:0] exp_avg;
  task automatic model(input bit half);
    int base; longint s; longint q;
    base = half ? HALF : 0;
    s = 0;
    for (int i = 0; i < HALF; i++) begin
      exp_addr[i] = 11'(base + i);
      exp_smp[i]  = mem[base + i][31:16];
      s += longint'($signed(exp_smp[i]));
    end
    q = s / HALF;
    if (s < 0 && (s % HALF) != 0) q = q - 1;
    exp_avg = 16'(q);
  endtask

  // kind: 0 ramp {addr,0}, 1 random word, 2 all -1, 3 alternating -3/+2.
  task automatic fill(input bit half, input int kind);
    int base;
    base = half ? HALF : 0;
    for (int i = 0; i < HALF; i++) begin
      case (kind)
        0:       mem[base + i] = {16'(base + i), 16'h0000};
        1:       mem[base + i] = $urandom;
        2:       mem[base + i] = {16'hFFFF, 16'($urandom)};
        default: mem[base + i] = {((i % 2) == 0) ? 16'hFFFD : 16'h0002, 16'($urandom)};
      endcase
    end
  endtask

  // Called at posedge+1: toggle the flag and measure read-enable / first-valid latency.
  task automatic start_xfer(input bit f);
    int n_en, n_vld;
    n_en = -1; n_vld = -1;
    clear_mon();
    i_wr_ram_2_flag = f;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk); #1;
      if (n_en  < 0 && bus.o_ram_en)    n_en  = k;
      if (n_vld < 0 && bus.o_smp_valid) n_vld = k;
    end
    check("en_latency", n_en, 1);
    check("vld_latency", n_vld, 2 + RAM_LATENCY);
  endtask

  task automatic wait_hs(input int n);
    int k;
    k = 0;
    while (hs_data.size() < n && k < BUDGET) begin @(negedge i_clk); #1; k++; end
    check("hs_wait", hs_data.size() >= n, 1);
    if (hs_data.size() < n) finish_sim();
  endtask

  task automatic finish_xfer(input bit half, input bit has_avg, input logic [15:0] tbl_avg);
    int k, errs;
    k = 0;
    while (avg_cnt == 0 && k < BUDGET) begin @(negedge i_clk); #1; k++; end
    check("avg_wait", avg_cnt != 0, 1);
    if (avg_cnt == 0) finish_sim();
    @(negedge i_clk); #1;
    check("idle_after_avg", o_debug_state, 0);
    check("avg_strobe_low", o_avg_valid, 0);
    repeat (3) @(negedge i_clk);
    #1;
    model(half);
    check("hs_count", hs_data.size(), HALF);
    check("rd_count", rd_addr.size(), HALF);
    errs = 0;
    for (int i = 0; i < HALF; i++) begin
      if (i < rd_addr.size() && rd_addr[i] != exp_addr[i]) errs++;
      if (i < hs_data.size() && (hs_data[i] != exp_smp[i] || hs_last[i] != (i == HALF - 1) ||
                                 hs_half[i] != half)) errs++;
    end
    check("sample_errs", errs, 0);
    check("stall_errs", stall_errs, 0);
    check("en_in_out", en_in_out_errs, 0);
    check("avg_pulses", avg_cnt, 1);
    check("avg_model", avg_seen, exp_avg);
    if (has_avg) check("avg_table", avg_seen, tbl_avg);
    check("avg_latency", avg_cyc - last_hs_cyc, 1);
  endtask

  typedef struct {
    bit          flag;
    int          ready_pct;
    int          fill;
    bit          exp_half;
    bit          has_avg;
    logic [15:0] exp_avg;
  } vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0] = '{1'b0, 100, 0, 1'b1, 1'b1, 16'd1535};
    tbl[1] = '{1'b1, 100, 0, 1'b0, 1'b1, 16'd511};
    tbl[2] = '{1'b0,  30, 1, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{1'b1,  30, 0, 1'b0, 1'b1, 16'd511};
    tbl[4] = '{1'b0, 100, 2, 1'b1, 1'b1, 16'hFFFF};
    tbl[5] = '{1'b1, 100, 3, 1'b0, 1'b1, 16'hFFFF};

    i_rst = 1'b1; i_wr_ram_2_flag = 1'b1; i_overrun_clr = 1'b0;
    #3 i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); #1;
    check("rst_addr", bus.o_ram_addr, 0);
    check("rst_en", bus.o_ram_en, 0);
    check("rst_smp_data", bus.o_smp_data, 0);
    check("rst_smp_valid", bus.o_smp_valid, 0);
    check("rst_smp_last", bus.o_smp_last, 0);
    check("rst_smp_half", bus.o_smp_half, 0);
    check("rst_avg_data", o_avg_data, 0);
    check("rst_avg_valid", o_avg_valid, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_state", o_debug_state, 7);
    tick();
    i_rst = 1'b1;
    @(negedge i_clk); #1;
    check("init_state", o_debug_state, 7);
    @(negedge i_clk); #1;
    check("idle_state", o_debug_state, 0);
    repeat (20) @(negedge i_clk);
    #1;
    check("no_spurious_read", rd_addr.size(), 0);
    check("still_idle", o_debug_state, 0);
    tick();

    for (int v = 0; v < 6; v++) begin
      fill(tbl[v].exp_half, tbl[v].fill);
      ready_pct = tbl[v].ready_pct;
      start_xfer(tbl[v].flag);
      finish_xfer(tbl[v].exp_half, tbl[v].has_avg, tbl[v].exp_avg);
      tick();
    end

    // Overrun: second toggle mid-transfer, with a clear in the same cycle (set must win).
    ready_pct = 100;
    check("ovr_before", o_overrun, 0);
    fill(1'b1, 0);
    start_xfer(1'b0);
    wait_hs(300);
    tick();
    i_wr_ram_2_flag = 1'b1; i_overrun_clr = 1'b1;
    tick();
    i_overrun_clr = 1'b0;
    check("ovr_set_wins", o_overrun, 1);
    finish_xfer(1'b1, 1'b1, 16'd1535);
    check("ovr_sticky", o_overrun, 1);
    repeat (40) @(negedge i_clk);
    #1;
    check("no_second_xfer", rd_addr.size(), HALF);
    check("no_second_avg", avg_cnt, 1);
    check("ovr_idle", o_debug_state, 0);
    tick();
    i_overrun_clr = 1'b1;
    tick();
    i_overrun_clr = 1'b0;
    check("ovr_cleared", o_overrun, 0);
    tick();

    // Reset at sample 500 of an upper-half transfer, then a clean lower-half transfer.
    start_xfer(1'b0);
    wait_hs(500);
    i_rst = 1'b0;
    #1;
    check("mid_rst_state", o_debug_state, 7);
    check("mid_rst_valid", bus.o_smp_valid, 0);
    check("mid_rst_en", bus.o_ram_en, 0);
    check("mid_rst_addr", bus.o_ram_addr, 0);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    repeat (5) tick();
    check("no_avg_on_rst", avg_cnt, 0);
    check("rst_then_idle", o_debug_state, 0);
    fill(1'b0, 0);
    start_xfer(1'b1);
    check("restart_base", (rd_addr.size() > 0) ? int'(rd_addr[0]) : -1, 0);
    finish_xfer(1'b0, 1'b1, 16'd511);

    finish_sim();
  end

endmodule
